i2c_write_expander: RTL

I2C_WRITE_EXPANDER -- requirements
Module: i2c_write_expander

---
 rtl/fmc_i2c_pkg.sv | 42 ++++
 rtl/i2c_write_expander.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fmc_i2c_pkg.sv
// Shared FMC I2C constants: PCA9548APW switch / PCA8574APW expander addressing,
// FSM state indices and step numbers used by the expander write and read engines.
package fmc_i2c_pkg;

    localparam logic [3:0] PCA9548_BASE = 4'b1110;
    localparam logic       PCA9548_A2   = 1'b1;
    localparam logic [6:0] PCA8574_ADR7 = 7'b0111000;
    localparam logic       RW_WRITE     = 1'b0;
    localparam logic       RW_READ      = 1'b1;

    localparam int unsigned ST_IDLE      = 0;
    localparam int unsigned ST_INIT      = 1;
    localparam int unsigned ST_REQ_BYTE  = 2;
    localparam int unsigned ST_WAIT_BYTE = 3;
    localparam int unsigned ST_CHECK_CNT = 4;
    localparam int unsigned ST_INC_CNTR  = 5;
    localparam int unsigned ST_DONE      = 6;
    localparam int unsigned ST_ERROR     = 7;

    typedef enum logic [7:0] {
        StIdle     = 8'(1 << ST_IDLE),
        StInit     = 8'(1 << ST_INIT),
        StReqByte  = 8'(1 << ST_REQ_BYTE),
        StWaitByte = 8'(1 << ST_WAIT_BYTE),
        StCheckCnt = 8'(1 << ST_CHECK_CNT),
        StIncCntr  = 8'(1 << ST_INC_CNTR),
        StDone     = 8'(1 << ST_DONE),
        StError    = 8'(1 << ST_ERROR)
    } fsm_state_e;

    localparam logic [2:0] STEP_CHAN_SEL = 3'd0;
    localparam logic [2:0] STEP_PORT_WR  = 3'd1;
    localparam logic [2:0] STEP_READBACK = 3'd2;
    localparam logic [2:0] STEP_DESEL_RB = 3'd3;
    localparam logic [2:0] STEP_DESEL    = 3'd2;

    // Write address of the PCA9548APW switch for a given FMC location.
    function automatic logic [7:0] pca9548_adr(input logic [1:0] fmc_loc);
        return {PCA9548_BASE, PCA9548_A2, fmc_loc, RW_WRITE};
    endfunction

endpackage

// File: rtl/i2c_write_expander.sv
// Selects an FMC I2C switch channel, writes the PCA8574APW port and deselects again.
// Define I2C_WRITE_EXPANDER_READBACK_EN to add a read-back/compare step before deselect.
module i2c_write_expander
    import fmc_i2c_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sm_start,
    output logic       sm_running,
    input  logic [1:0] fmc_loc,
    input  logic [7:0] channel_sel,
    input  logic [7:0] reg_in,
    output logic       write_done,
    output logic       write_error,
    output logic       readback_mismatch,
    output logic [7:0] rd_value,
    input  logic       i2c_wr_byte_done,
    input  logic       i2c_byte_error,
    input  logic       i2c_byte_rdy,
    input  logic [7:0] i2c_rd_dat,
    output logic       i2c_rd_byte_ctrl,
    output logic [7:0] i2c_dev_adr,
    output logic [7:0] i2c_reg_dat,
    output logic       i2c_start_write,
    output logic       i2c_start_read
);

`ifdef I2C_WRITE_EXPANDER_READBACK_EN
    localparam logic [2:0] LastStep   = STEP_DESEL_RB;
    localparam bit         ReadbackEn = 1'b1;
`else
    localparam logic [2:0] LastStep   = STEP_DESEL;
    localparam bit         ReadbackEn = 1'b0;
`endif

    fsm_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] reg_q, reg_d;
    logic       rd_step;
    logic       busy_d;
    logic [7:0] step_adr, step_dat;
    logic       step_rd;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        reg_d   = reg_q;
        unique case (state_q)
            StIdle:     state_d = StInit;
            StInit: begin
                if (sm_start) begin
                    state_d = StReqByte;
                    reg_d   = reg_in;
                end
            end
            StReqByte:  state_d = StWaitByte;
            StWaitByte: begin
                if (i2c_byte_error) begin
                    state_d = StError;
                end else if (i2c_wr_byte_done || i2c_byte_rdy) begin
                    state_d = StCheckCnt;
                end
            end
            StCheckCnt: state_d = (cnt_q == LastStep) ? StDone : StIncCntr;
            StIncCntr:  state_d = StReqByte;
            StDone:     state_d = StInit;
            StError:    state_d = StInit;
            default:    state_d = StIdle;
        endcase
        if (state_d == StInit) begin
            cnt_d = '0;
        end else if (state_d == StIncCntr && state_q != StIncCntr) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    assign rd_step = ReadbackEn && (cnt_d == STEP_READBACK);
    assign busy_d  = (state_d == StReqByte) || (state_d == StWaitByte);

    // Byte descriptor for the upcoming step, loaded ahead of the start request.
    always_comb begin
        step_adr = pca9548_adr(fmc_loc);
        step_dat = 8'h00;
        step_rd  = RW_WRITE;
        if (cnt_d == STEP_CHAN_SEL) begin
            step_dat = channel_sel;
        end else if (cnt_d == STEP_PORT_WR) begin
            step_adr = {PCA8574_ADR7, RW_WRITE};
            step_dat = reg_d;
        end else if (rd_step) begin
            step_adr = {PCA8574_ADR7, RW_READ};
            step_rd  = RW_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= StIdle;
            cnt_q             <= '0;
            reg_q             <= '0;
            sm_running        <= 1'b0;
            write_done        <= 1'b0;
            write_error       <= 1'b0;
            readback_mismatch <= 1'b0;
            rd_value          <= 8'h00;
            i2c_rd_byte_ctrl  <= 1'b0;
            i2c_dev_adr       <= 8'h00;
            i2c_reg_dat       <= 8'h00;
            i2c_start_write   <= 1'b0;
            i2c_start_read    <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            reg_q             <= reg_d;
            sm_running        <= !(state_d inside {StIdle, StInit});
            write_done        <= (state_d == StDone);
            write_error       <= (state_d == StError);
            // rd_value was captured at the read step, well before DONE is entered.
            readback_mismatch <= ReadbackEn && (state_d == StDone) && (rd_value != reg_q);
            i2c_rd_byte_ctrl  <= step_rd;
            i2c_dev_adr       <= step_adr;
            i2c_reg_dat       <= step_dat;
            i2c_start_write   <= busy_d && !rd_step;
            i2c_start_read    <= busy_d && rd_step;
            if (ReadbackEn && rd_step && state_q == StWaitByte && state_d == StCheckCnt) begin
                rd_value <= i2c_rd_dat;
            end
        end
    end

endmodule
